fifo_rd_adapter: RTL

FIFO_RD_ADAPTER -- requirements
Module: fifo_rd_adapter

---
 rtl/fifo_pkg.sv | 10 +
 rtl/fifo_rd_skid.sv | 56 +++++
 rtl/fifo_rd_adapter.sv | 71 +++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared defaults and types for the FIFO read-side stream adapter.
package fifo_pkg;
  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned CNT_WIDTH_DEF  = 16;

  typedef logic [1:0] occ_t;
  localparam occ_t OCC_EMPTY = 2'd0;
  localparam occ_t OCC_ONE   = 2'd1;
  localparam occ_t OCC_FULL  = 2'd2;
endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry registered output buffer; head is the presented stream word.
module fifo_rd_skid
  import fifo_pkg::*;
#(
  parameter int unsigned P_DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    push,
  input  logic                    pop,
  input  logic [P_DATA_WIDTH-1:0] data,
  output logic [P_DATA_WIDTH-1:0] head,
  output occ_t                    occ
);

  logic [P_DATA_WIDTH-1:0] tail;

  always_ff @(posedge clk) begin
    if (rst) begin
      occ  <= OCC_EMPTY;
      head <= '0;
      tail <= '0;
    end else if (flush) begin
      occ <= OCC_EMPTY;
    end else begin
      case (occ)
        OCC_EMPTY: begin
          if (push) begin
            head <= data;
            occ  <= OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (push && pop) begin
            head <= data;
          end else if (push) begin
            tail <= data;
            occ  <= OCC_FULL;
          end else if (pop) begin
            occ <= OCC_EMPTY;
          end
        end
        default: begin
          // Full: a push is only legal alongside a pop, so the tail refills as it advances.
          if (pop) begin
            head <= tail;
            if (push) tail <= data;
            else      occ  <= OCC_ONE;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/fifo_rd_adapter.sv
// Converts a FIFO read port (rden / one-cycle-late rddata_valid) into a valid/ready stream.
module fifo_rd_adapter
  import fifo_pkg::*;
#(
  parameter int unsigned P_DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned P_CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                    rd_clk,
  input  logic                    rd_rst,
  input  logic                    fifo_empty,
  output logic                    rden,
  input  logic [P_DATA_WIDTH-1:0] rdata,
  input  logic                    rddata_valid,
  output logic                    m_valid,
  output logic [P_DATA_WIDTH-1:0] m_data,
  input  logic                    m_ready,
  input  logic                    flush,
  output logic [P_CNT_WIDTH-1:0]  rd_beat_cnt,
  output logic                    underflow_err
);

  occ_t occ;
  logic inflight;
  logic drop;
  logic pop;
  logic accept;
  logic overfull;
  logic capture;
  logic stray;

  assign m_valid = (occ != OCC_EMPTY);
  assign pop     = m_valid & m_ready;

  // Credit check: buffered + in-flight words after this cycle's pop must leave room for one more.
  assign rden = ~rd_rst & ~fifo_empty & ~flush &
                (({1'b0, occ} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));

  // drop covers the cycle after flush or reset, when a returning word belongs to discarded state.
  assign accept   = rddata_valid & ~drop & ~flush & ~rd_rst;
  assign overfull = (occ == OCC_FULL) & ~pop;
  assign capture  = accept & inflight & ~overfull;
  assign stray    = accept & (~inflight | overfull);

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      inflight      <= 1'b0;
      drop          <= 1'b1;
      rd_beat_cnt   <= '0;
      underflow_err <= 1'b0;
    end else begin
      inflight <= rden;
      drop     <= flush;
      if (pop)   rd_beat_cnt   <= rd_beat_cnt + P_CNT_WIDTH'(1);
      if (stray) underflow_err <= 1'b1;
    end
  end

  fifo_rd_skid #(
    .P_DATA_WIDTH (P_DATA_WIDTH)
  ) u_skid (
    .clk   (rd_clk),
    .rst   (rd_rst),
    .flush (flush),
    .push  (capture),
    .pop   (pop),
    .data  (rdata),
    .head  (m_data),
    .occ   (occ)
  );

endmodule
